// File: rtl/fetch_pkg.sv
// Shared fetch-sequencer constants: FSM state encoding and address register file selects.
// Also used by the control unit, so the encodings must not change.
package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RD_LO = 2'd1,
        RD_HI = 2'd2,
        DONE  = 2'd3
    } fetch_state_e;

    // RegSel enables are active-low: bit2=PC, bit1=AR, bit0=SP.
    localparam logic [2:0] ARF_REGSEL_NONE = 3'b111;
    localparam logic [2:0] ARF_REGSEL_PC   = 3'b011;

    localparam logic [2:0] FUNSEL_INC  = 3'b001;
    localparam logic [2:0] FUNSEL_HOLD = 3'b000;

    function automatic logic is_read_state(input fetch_state_e s);
        return (s == RD_LO) || (s == RD_HI);
    endfunction

endpackage

// File: rtl/instruction_fetch_unit.sv
// Two-byte little-endian instruction fetch with PC post-increment per accepted byte.
// Optional macro FETCH_TIMEOUT_EN adds a per-byte wait-cycle timeout with an Error pulse.
module instruction_fetch_unit
    import fetch_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 15
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        Start,
    input  logic [15:0] Address,
    input  logic [7:0]  MemData,
    input  logic        MemReady,
    output logic        MemRd,
    output logic [15:0] MemAddr,
    output logic [2:0]  ArfRegSel,
    output logic [2:0]  ArfFunSel,
    output logic [15:0] IROut,
    output logic        IRValid,
    output logic        Busy,
    output logic        Error
);

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be in 1..255");
    end

    fetch_state_e state_q, state_d;
    logic [15:0]  ir_q, ir_d;
    logic         ir_valid_q, ir_valid_d;
    logic [7:0]   lo_byte_q, lo_byte_d;
    logic         rd_active;
    logic         accept;
    logic         timeout;

`ifdef FETCH_TIMEOUT_EN
    localparam logic [7:0] TimeoutLast = 8'(TIMEOUT_CYCLES - 1);

    logic [7:0] wait_cnt_q, wait_cnt_d;
    logic       error_q, error_d;
`endif

    // Reset masks the memory request and the PC increment in the same cycle.
    assign rd_active = is_read_state(state_q) && !Reset;
    assign accept    = rd_active && MemReady;

    always_comb begin
        timeout = 1'b0;
`ifdef FETCH_TIMEOUT_EN
        // Any non-wait cycle (entry, accepted byte, idle) leaves the counter cleared.
        wait_cnt_d = 8'd0;
        if (rd_active && !MemReady) begin
            if (wait_cnt_q == TimeoutLast) begin
                timeout = 1'b1;
            end else begin
                wait_cnt_d = wait_cnt_q + 8'd1;
            end
        end
        error_d = timeout;
`endif
    end

    always_comb begin
        state_d    = state_q;
        ir_d       = ir_q;
        lo_byte_d  = lo_byte_q;
        ir_valid_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (Start) state_d = RD_LO;
            end
            RD_LO: begin
                if (MemReady) begin
                    lo_byte_d = MemData;
                    state_d   = RD_HI;
                end else if (timeout) begin
                    state_d = IDLE;
                end
            end
            RD_HI: begin
                if (MemReady) begin
                    ir_d       = {MemData, lo_byte_q};
                    ir_valid_d = 1'b1;
                    state_d    = DONE;
                end else if (timeout) begin
                    state_d = IDLE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q    <= IDLE;
            ir_q       <= 16'h0000;
            ir_valid_q <= 1'b0;
            lo_byte_q  <= 8'h00;
        end else begin
            state_q    <= state_d;
            ir_q       <= ir_d;
            ir_valid_q <= ir_valid_d;
            lo_byte_q  <= lo_byte_d;
        end
    end

`ifdef FETCH_TIMEOUT_EN
    always_ff @(posedge Clock) begin
        if (Reset) begin
            wait_cnt_q <= 8'd0;
            error_q    <= 1'b0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
            error_q    <= error_d;
        end
    end

    assign Error = error_q;
`else
    assign Error = 1'b0;
`endif

    assign MemRd     = rd_active;
    assign MemAddr   = rd_active ? Address : 16'h0000;
    assign ArfRegSel = accept ? ARF_REGSEL_PC : ARF_REGSEL_NONE;
    assign ArfFunSel = accept ? FUNSEL_INC : FUNSEL_HOLD;
    assign IROut     = ir_q;
    assign IRValid   = ir_valid_q;
    assign Busy      = (state_q != IDLE);

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit with a byte memory and a PC register model.
// Define FETCH_TIMEOUT_EN to also exercise the timeout path (TIMEOUT_CYCLES=4).
`timescale 1ns/1ps
module tb_instruction_fetch_unit;

`ifdef FETCH_TIMEOUT_EN
    localparam int unsigned TbTimeout = 4;
`else
    localparam int unsigned TbTimeout = 15;
`endif

    logic        Clock = 1'b0;
    logic        Reset;
    logic        Start;
    logic [15:0] Address;
    logic [7:0]  MemData;
    logic        MemReady;
    logic        MemRd;
    logic [15:0] MemAddr;
    logic [2:0]  ArfRegSel;
    logic [2:0]  ArfFunSel;
    logic [15:0] IROut;
    logic        IRValid;
    logic        Busy;
    logic        Error;

    logic [15:0] pc;
    logic        pc_load = 1'b0;
    logic [15:0] pc_load_val = 16'h0000;
    int          inc_count = 0;
    logic [7:0]  mem [0:65535];

    int n_checks = 0;
    int n_fail   = 0;

    instruction_fetch_unit #(
        .TIMEOUT_CYCLES(TbTimeout)
    ) u_dut (
        .Clock    (Clock),
        .Reset    (Reset),
        .Start    (Start),
        .Address  (Address),
        .MemData  (MemData),
        .MemReady (MemReady),
        .MemRd    (MemRd),
        .MemAddr  (MemAddr),
        .ArfRegSel(ArfRegSel),
        .ArfFunSel(ArfFunSel),
        .IROut    (IROut),
        .IRValid  (IRValid),
        .Busy     (Busy),
        .Error    (Error)
    );

    always #5 Clock = ~Clock;

    assign Address = pc;
    assign MemData = mem[MemAddr];

    // Address register file PC model: loads from the bench, increments on PC select + INC.
    always @(posedge Clock) begin
        if (pc_load) pc <= pc_load_val;
        else if (ArfRegSel == 3'b011 && ArfFunSel == 3'b001) pc <= pc + 16'd1;
        if (ArfRegSel == 3'b011) inc_count <= inc_count + 1;
    end

    task automatic set_pc(input logic [15:0] v);
        @(negedge Clock);
        Start = 1'b0;
        pc_load = 1'b1;
        pc_load_val = v;
        @(negedge Clock);
        pc_load = 1'b0;
    endtask

    // Runs one fetch (Start in cycle 0) with lo_w / hi_w wait cycles and records observations.
    task automatic drive_fetch(input int lo_w, input int hi_w, input logic [15:0] start_pc,
                               output int valid_cyc, output int sel_cnt, output int sel_bad,
                               output int addr_bad, output logic [15:0] ir_seen);
        logic [15:0] exp_addr;
        logic        exp_rd;
        logic        acc;
        valid_cyc = -1;
        sel_cnt = 0;
        sel_bad = 0;
        addr_bad = 0;
        ir_seen = 16'hxxxx;
        for (int n = 0; n <= lo_w + hi_w + 5; n++) begin
            @(negedge Clock);
            Start = (n == 0);
            if (n >= 1 && n <= lo_w) MemReady = 1'b0;
            else if (n >= lo_w + 2 && n <= lo_w + hi_w + 1) MemReady = 1'b0;
            else MemReady = 1'b1;
            #1;
            if (n >= 1 && n <= lo_w + 1) begin
                exp_addr = start_pc;
                exp_rd = 1'b1;
            end else if (n >= lo_w + 2 && n <= lo_w + hi_w + 2) begin
                exp_addr = start_pc + 16'd1;
                exp_rd = 1'b1;
            end else begin
                exp_addr = 16'h0000;
                exp_rd = 1'b0;
            end
            if (MemRd !== exp_rd || MemAddr !== exp_addr) addr_bad++;
            acc = (n == lo_w + 1) || (n == lo_w + hi_w + 2);
            if (ArfRegSel === 3'b011) sel_cnt++;
            if (ArfRegSel !== (acc ? 3'b011 : 3'b111)) sel_bad++;
            if (IRValid === 1'b1 && valid_cyc < 0) begin
                valid_cyc = n;
                ir_seen = IROut;
            end
        end
        Start = 1'b0;
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        Start = 1'b1;
        MemReady = 1'b1;
        @(negedge Clock);
        @(negedge Clock);
        #1;
        n_checks++;
        if (MemRd !== 1'b0) begin
            n_fail++; $display("FAIL reset_memrd: got %b want 0", MemRd);
        end
        n_checks++;
        if (ArfRegSel !== 3'b111 || ArfFunSel !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_arf: got sel=%b fun=%b want 111/000", ArfRegSel, ArfFunSel);
        end
        n_checks++;
        if (IROut !== 16'h0000 || IRValid !== 1'b0) begin
            n_fail++; $display("FAIL reset_ir: got %h/%b want 0000/0", IROut, IRValid);
        end
        n_checks++;
        if (Busy !== 1'b0 || Error !== 1'b0) begin
            n_fail++; $display("FAIL reset_busy_err: got %b/%b want 0/0", Busy, Error);
        end
        @(negedge Clock);
        Reset = 1'b0;
        Start = 1'b0;
        #1;
        n_checks++;
        if (Busy !== 1'b0 || MemRd !== 1'b0) begin
            n_fail++; $display("FAIL post_reset_idle: got busy=%b rd=%b want 0/0", Busy, MemRd);
        end
    endtask

    task automatic test_basic();
        int vc, sc, sb, ab;
        logic [15:0] ir;
        mem[16'h0010] = 8'h34;
        mem[16'h0011] = 8'h12;
        set_pc(16'h0010);
        drive_fetch(0, 0, 16'h0010, vc, sc, sb, ab, ir);
        n_checks++;
        if (vc !== 3) begin n_fail++; $display("FAIL basic_latency: got %0d want 3", vc); end
        n_checks++;
        if (ir !== 16'h1234) begin n_fail++; $display("FAIL basic_ir: got %h want 1234", ir); end
        n_checks++;
        if (pc !== 16'h0012) begin n_fail++; $display("FAIL basic_pc: got %h want 0012", pc); end
        n_checks++;
        if (sc !== 2 || sb !== 0) begin
            n_fail++; $display("FAIL basic_regsel: got cnt=%0d bad=%0d want 2/0", sc, sb);
        end
        n_checks++;
        if (ab !== 0) begin n_fail++; $display("FAIL basic_addr: got %0d bad want 0", ab); end
        n_checks++;
        if (Busy !== 1'b0 || IRValid !== 1'b0 || IROut !== 16'h1234) begin
            n_fail++;
            $display("FAIL basic_after: got busy=%b v=%b ir=%h want 0/0/1234", Busy, IRValid, IROut);
        end
    endtask

    task automatic test_wait_states();
        int vc, sc, sb, ab;
        logic [15:0] ir;
        set_pc(16'h0010);
        drive_fetch(3, 3, 16'h0010, vc, sc, sb, ab, ir);
        n_checks++;
        if (vc !== 9) begin n_fail++; $display("FAIL wait_latency: got %0d want 9", vc); end
        n_checks++;
        if (ir !== 16'h1234) begin n_fail++; $display("FAIL wait_ir: got %h want 1234", ir); end
        n_checks++;
        if (ab !== 0) begin n_fail++; $display("FAIL wait_addr_stable: got %0d bad want 0", ab); end
        n_checks++;
        if (sc !== 2 || sb !== 0) begin
            n_fail++; $display("FAIL wait_no_inc: got cnt=%0d bad=%0d want 2/0", sc, sb);
        end
        n_checks++;
        if (pc !== 16'h0012) begin n_fail++; $display("FAIL wait_pc: got %h want 0012", pc); end
        n_checks++;
        if (Error !== 1'b0) begin n_fail++; $display("FAIL wait_error: got %b want 0", Error); end
    endtask

    task automatic test_wrap();
        int vc, sc, sb, ab;
        logic [15:0] ir;
        mem[16'hFFFF] = 8'hCD;
        mem[16'h0000] = 8'hAB;
        set_pc(16'hFFFF);
        drive_fetch(0, 0, 16'hFFFF, vc, sc, sb, ab, ir);
        n_checks++;
        if (ir !== 16'hABCD || vc !== 3) begin
            n_fail++; $display("FAIL wrap_ir: got %h at %0d want ABCD at 3", ir, vc);
        end
        n_checks++;
        if (pc !== 16'h0001) begin n_fail++; $display("FAIL wrap_pc: got %h want 0001", pc); end
        n_checks++;
        if (ab !== 0) begin n_fail++; $display("FAIL wrap_addr: got %0d bad want 0", ab); end
    endtask

    task automatic test_reset_mid_fetch();
        int inc0;
        mem[16'h0100] = 8'h11;
        mem[16'h0101] = 8'h22;
        set_pc(16'h0100);
        inc0 = inc_count;
        @(negedge Clock); Start = 1'b1; MemReady = 1'b1;
        @(negedge Clock); Start = 1'b0; MemReady = 1'b1;
        @(negedge Clock); Start = 1'b1; MemReady = 1'b0;
        #1;
        n_checks++;
        if (Busy !== 1'b1 || MemAddr !== 16'h0101) begin
            n_fail++; $display("FAIL mid_rd_hi: got busy=%b addr=%h want 1/0101", Busy, MemAddr);
        end
        @(negedge Clock); Start = 1'b0; Reset = 1'b1; MemReady = 1'b1;
        #1;
        n_checks++;
        if (MemRd !== 1'b0 || ArfRegSel !== 3'b111 || ArfFunSel !== 3'b000) begin
            n_fail++;
            $display("FAIL mid_reset_comb: got rd=%b sel=%b fun=%b want 0/111/000",
                     MemRd, ArfRegSel, ArfFunSel);
        end
        @(negedge Clock); Reset = 1'b0;
        #1;
        n_checks++;
        if (Busy !== 1'b0 || IROut !== 16'h0000 || IRValid !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_after: got busy=%b ir=%h v=%b want 0/0000/0", Busy, IROut, IRValid);
        end
        n_checks++;
        if (pc !== 16'h0101 || inc_count - inc0 !== 1) begin
            n_fail++; $display("FAIL mid_pc: got %h incs=%0d want 0101/1", pc, inc_count - inc0);
        end
        @(negedge Clock);
        #1;
        n_checks++;
        if (Busy !== 1'b0 || MemRd !== 1'b0) begin
            n_fail++; $display("FAIL mid_no_refetch: got busy=%b rd=%b want 0/0", Busy, MemRd);
        end
    endtask

    task automatic test_back_to_back();
        int          nv = 0;
        int          cyc [4];
        logic [15:0] word [4];
        for (int i = 0; i < 8; i++) mem[16'h0200 + 16'(i)] = 8'(i + 1);
        set_pc(16'h0200);
        for (int n = 0; n <= 15; n++) begin
            @(negedge Clock);
            Start = (n <= 8);
            MemReady = 1'b1;
            #1;
            if (IRValid === 1'b1 && nv < 4) begin
                cyc[nv] = n;
                word[nv] = IROut;
                nv++;
            end
        end
        Start = 1'b0;
        n_checks++;
        if (nv !== 3) begin n_fail++; $display("FAIL b2b_count: got %0d want 3", nv); end
        if (nv >= 3) begin
            n_checks++;
            if (cyc[0] !== 3 || cyc[1] !== 7 || cyc[2] !== 11) begin
                n_fail++;
                $display("FAIL b2b_cycles: got %0d,%0d,%0d want 3,7,11", cyc[0], cyc[1], cyc[2]);
            end
            n_checks++;
            if (word[0] !== 16'h0201 || word[1] !== 16'h0403 || word[2] !== 16'h0605) begin
                n_fail++;
                $display("FAIL b2b_words: got %h,%h,%h want 0201,0403,0605",
                         word[0], word[1], word[2]);
            end
        end
        n_checks++;
        if (pc !== 16'h0206) begin n_fail++; $display("FAIL b2b_pc: got %h want 0206", pc); end
    endtask

`ifdef FETCH_TIMEOUT_EN
    task automatic test_timeout();
        int err_cyc = -1;
        int err_cnt = 0;
        int valid_cnt = 0;
        logic busy5 = 1'b1;
        logic [15:0] ir0;
        ir0 = IROut;
        set_pc(16'h0300);
        for (int n = 0; n <= 8; n++) begin
            @(negedge Clock);
            Start = (n == 0);
            MemReady = 1'b0;
            #1;
            if (Error === 1'b1) begin
                err_cnt++;
                if (err_cyc < 0) err_cyc = n;
            end
            if (IRValid === 1'b1) valid_cnt++;
            if (n == 5) busy5 = Busy;
        end
        MemReady = 1'b1;
        n_checks++;
        if (err_cyc !== 5 || err_cnt !== 1) begin
            n_fail++; $display("FAIL timeout_error: got cyc=%0d cnt=%0d want 5/1", err_cyc, err_cnt);
        end
        n_checks++;
        if (busy5 !== 1'b0) begin n_fail++; $display("FAIL timeout_busy: got %b want 0", busy5); end
        n_checks++;
        if (valid_cnt !== 0 || IROut !== ir0) begin
            n_fail++;
            $display("FAIL timeout_ir: got v=%0d ir=%h want 0/%h", valid_cnt, IROut, ir0);
        end
        n_checks++;
        if (pc !== 16'h0300) begin n_fail++; $display("FAIL timeout_pc: got %h want 0300", pc); end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_wait_states();
        test_wrap();
        test_reset_mid_fetch();
        test_back_to_back();
`ifdef FETCH_TIMEOUT_EN
        test_timeout();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
- Fetch sequencer that sits directly downstream of the address register file and uses its OutD output (PC selected) as the fetch address.
- Reads two consecutive bytes from byte-wide memory through a ready handshake and assembles them little-endian into a 16-bit instruction word.
- Drives the address register file's RegSel/FunSel inputs to post-increment PC once per byte fetched.
- Sits between the control unit, which issues Start, and the instruction register consumer.

Parameters:
- TIMEOUT_CYCLES, 15: maximum consecutive wait cycles per byte read. Used only when FETCH_TIMEOUT_EN is defined. Legal range 1..255.

Ports:
- Clock  input  1  system clock; all state updates on the rising edge.
- Reset  input  1  synchronous, active-high reset.
- Start  input  1  fetch request; sampled only in IDLE.
- Address  input  16  current PC value, taken from address register file OutD with OutDSel=2'b00.
- MemData  input  8  read data from memory; valid when MemReady=1.
- MemReady  input  1  memory read completes this cycle.
- MemRd  output  1  read request to memory.
- MemAddr  output  16  memory address; equals Address whenever MemRd=1, otherwise 16'h0000.
- ArfRegSel  output  3  RegSel to address register file. Active-low enables: bit2=PC, bit1=AR, bit0=SP.
- ArfFunSel  output  3  FunSel to address register file.
- IROut  output  16  assembled instruction word.
- IRValid  output  1  one-cycle pulse when IROut is updated.
- Busy  output  1  high in every state except IDLE.
- Error  output  1  timeout pulse; constant 0 when FETCH_TIMEOUT_EN is not defined.

Behaviour:
- States are IDLE, RD_LO, RD_HI, DONE.
- On Reset, the next state is IDLE. Registered outputs reset to: IROut=16'h0000, IRValid=0, Error=0, low-byte latch=8'h00, wait counter=0.
- Combinational outputs while Reset=1: MemRd=0, ArfRegSel=3'b111, ArfFunSel=3'b000. This means no PC update occurs in the reset cycle.
- IDLE: if Start=1, go to RD_LO. Otherwise stay in IDLE.
- RD_LO: MemRd=1.
  - If MemReady=1: latch MemData into the low byte, drive ArfRegSel=3'b011 and ArfFunSel=3'b001 (PC increment, Mealy, same cycle), then go to RD_HI.
  - If MemReady=0: stay in RD_LO with ArfRegSel=3'b111.
- RD_HI: same as RD_LO.
  - On MemReady=1: IROut <= {MemData, low byte}, increment PC, go to DONE.
- DONE: IRValid=1 for exactly this cycle, then unconditionally go to IDLE.
- In all states other than those listed above, ArfRegSel=3'b111 and ArfFunSel=3'b000 (all register enables off).
- Latency with zero wait states: Start sampled in cycle 0, RD_LO in cycle 1, RD_HI in cycle 2, IRValid in cycle 3. Each wait cycle adds 1.
- PC wraps: a fetch at 16'hFFFF reads the low byte from FFFF and the high byte from 0000. The wrap is done by the register's own increment; the block does no special handling.
- Start in any state other than IDLE is ignored. Start held high through DONE causes a new fetch to begin the cycle after DONE.
- MemReady outside RD_LO/RD_HI is ignored.
- IROut holds its value between fetches. It changes only on the RD_HI→DONE edge or on Reset.
- Reset mid-fetch abandons the fetch and leaves IROut at 0. Any PC increment already applied stays applied.

Optional Feature:
- Macro FETCH_TIMEOUT_EN.
- Defined:
  - An 8-bit wait counter clears on entry to RD_LO/RD_HI and on every accepted byte. It increments on each MemReady=0 cycle in those states.
  - When the counter reaches TIMEOUT_CYCLES while MemReady=0, the block pulses Error for 1 cycle, goes to IDLE, does not pulse IRValid, leaves IROut unchanged and does not increment PC that cycle.
- Not defined: no counter, Error tied 0, the block waits indefinitely for MemReady.

Decomposition:
- Shared package fetch_pkg holds:
  - State enum (IDLE=2'd0, RD_LO=2'd1, RD_HI=2'd2, DONE=2'd3).
  - ARF_REGSEL_NONE=3'b111 and ARF_REGSEL_PC=3'b011.
  - FUNSEL_INC=3'b001 and FUNSEL_HOLD=3'b000.
- This block and the control unit share these constants.
- No sub-module: a single FSM plus datapath registers.

Test Plan:
- Reset, then Start at PC=16'h0010 with memory[0010]=8'h34, memory[0011]=8'h12 and MemReady always 1 -> IRValid in cycle 3, IROut=16'h1234, PC=16'h0012, exactly two ArfRegSel=3'b011 cycles.
- Same fetch with MemReady held low 3 cycles in each read state -> IRValid in cycle 9, IROut=16'h1234, MemAddr stable during waits, no PC increment during waits.
- PC=16'hFFFF, mem[FFFF]=8'hCD, mem[0000]=8'hAB -> IROut=16'hABCD, PC=16'h0001.
- Start pulsed in RD_HI and Reset asserted in RD_HI after the low byte was accepted -> no second fetch, IDLE next cycle, IROut=0, PC advanced by 1 only.
- With FETCH_TIMEOUT_EN, TIMEOUT_CYCLES=4, MemReady never asserted -> Error pulse after 4 wait cycles, Busy drops, IRValid never asserted, PC unchanged.
- Start held high continuously -> back-to-back fetches with IRValid every 4 cycles and IROut values matching sequential words.
